// File: rtl/frank_pkg.sv
// Shared FRANK6000 definitions: flag bit positions, branch condition codes,
// sequencer state encoding and the branch-condition helper.
package frank_pkg;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  typedef enum logic [1:0] {
    BR_ALWAYS = 2'b00,
    BR_Z      = 2'b01,
    BR_N      = 2'b10,
    BR_C      = 2'b11
  } br_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_HALT  = 3'd4
  } seq_state_e;

  function automatic logic br_cond(input logic [1:0] op, input logic [2:0] fl);
    logic res;
    res = 1'b0;
    case (br_op_e'(op))
      BR_ALWAYS: res = 1'b1;
      BR_Z:      res = fl[FLAG_Z];
      BR_N:      res = fl[FLAG_N];
      BR_C:      res = fl[FLAG_C];
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pc_stack.sv
// Return-address LIFO for the sequencer; push/pop are ignored when full/empty.
import frank_pkg::*;

module pc_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [SW-1:0] sp;
  logic [AW-1:0] top_idx;
  logic [AW-1:0] wr_idx;

  assign full    = (sp == SW'(DEPTH));
  assign empty   = (sp == '0);
  assign top_idx = AW'(sp - SW'(1));
  assign wr_idx  = AW'(sp);
  assign top     = mem[top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SW'(1);
    end else if (pop && !empty) begin
      sp <= sp - SW'(1);
    end
  end

  // Storage needs no reset: nothing is read until it has been pushed.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_idx] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// FRANK6000 fetch/wait/execute sequencer owning the PC and status flags.
// Define PC_STACK_EN to add the CALL/RET return stack (pc_stack).
import frank_pkg::*;

// state | meaning
// IDLE  | after reset, waits for start
// FETCH | program-memory read at pc
// WAIT  | memory data valid, instruction register loads
// EXEC  | decoder inputs sampled, pc/flags updated
// HALT  | stopped; start resumes at pc+1, only rst returns to IDLE
module pc_sequencer #(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [PC_W-1:0] pm_addr,
  output logic            fetch_en,
  output logic            ir_load,
  output logic            exec_en,
  input  logic            is_branch,
  input  logic [1:0]      br_op,
  input  logic [PC_W-1:0] br_target,
  input  logic            is_call,
  input  logic            is_ret,
  input  logic            halt,
  input  logic            alu_flag_we,
  input  logic [2:0]      flags_in,
  output logic [2:0]      flags,
  output logic            jump_taken,
  output logic            halted,
  output logic            stack_err
);

  if (STACK_DEPTH < 2) begin : g_depth_chk
    $error("pc_sequencer: STACK_DEPTH must be at least 2");
  end

  seq_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic [2:0]      flags_q, flags_d;
  logic            jump_q, jump_d;

  assign pc_inc = pc_q + PC_W'(1);

`ifdef PC_STACK_EN
  logic            err_q, err_d;
  logic            stk_push, stk_pop, stk_full, stk_empty;
  logic [PC_W-1:0] stk_top;

  pc_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_inc),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  assign stack_err = err_q;
`else
  assign stack_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      flags_q <= '0;
      jump_q  <= 1'b0;
`ifdef PC_STACK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      jump_q  <= jump_d;
`ifdef PC_STACK_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    jump_d  = 1'b0;
`ifdef PC_STACK_EN
    err_d    = err_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
`endif
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_FETCH;
        // Branch condition reads flags_q, so it never sees this cycle's write.
        if (alu_flag_we) flags_d = flags_in;
        if (halt) begin
          state_d = ST_HALT;
`ifdef PC_STACK_EN
        end else if (is_ret) begin
          if (stk_empty) begin
            err_d   = 1'b1;
            state_d = ST_HALT;
          end else begin
            stk_pop = 1'b1;
            pc_d    = stk_top;
          end
        end else if (is_call) begin
          if (stk_full) begin
            err_d   = 1'b1;
            state_d = ST_HALT;
          end else begin
            stk_push = 1'b1;
            pc_d     = br_target;
          end
`else
        end else if (is_ret) begin
          pc_d = pc_inc;
        end else if (is_call) begin
          pc_d = br_target;
`endif
        end else if (is_branch && br_cond(br_op, flags_q)) begin
          pc_d   = br_target;
          jump_d = 1'b1;
        end else begin
          pc_d = pc_inc;
        end
      end
      ST_HALT: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = pc_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // jump_taken is registered: it is high in the FETCH cycle at the target.
  assign pm_addr    = pc_q;
  assign flags      = flags_q;
  assign jump_taken = jump_q;
  assign fetch_en   = (state_q == ST_FETCH);
  assign ir_load    = (state_q == ST_WAIT);
  assign exec_en    = (state_q == ST_EXEC);
  assign halted     = (state_q == ST_HALT);

endmodule
